// File: rtl/mem_access_unit_pkg.sv
// Shared types for the memory access unit.
//   state_t : FSM encoding (2-bit)
//   acc_t   : decoded access type
//   mreq_t  : request latched on IDLE->BUSY and held for the whole access
// TIMEOUT_CYCLES_DEF is the default BUSY-cycle limit used when the
// MEM_TIMEOUT_EN build option is enabled.
package mem_access_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_DONE  = 2'd2,
    ST_ERROR = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    ACC_NONE  = 2'd0,
    ACC_FETCH = 2'd1,
    ACC_LOAD  = 2'd2,
    ACC_STORE = 2'd3
  } acc_t;

  typedef struct packed {
    acc_t        kind;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mreq_t;

  localparam int TIMEOUT_CYCLES_DEF = 16;

  // Fetch wins if the controller ever raises IRWrite together with a data access.
  function automatic acc_t decode_acc(input logic irwrite, input logic adrsrc,
                                      input logic memwrite);
    if (irwrite)                return ACC_FETCH;
    else if (adrsrc && memwrite) return ACC_STORE;
    else if (adrsrc)             return ACC_LOAD;
    else                         return ACC_NONE;
  endfunction

endpackage

// File: rtl/mem_watchdog.sv
// BUSY-cycle watchdog for the memory access unit.
//   clk, rst : clock, async active-high reset
//   clear    : restart count (BUSY entry)
//   enable   : count this cycle (BUSY without ack)
//   expired  : this counted cycle is the LIMIT-th one
module mem_watchdog #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [7:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         cnt <= '0;
    else if (clear)  cnt <= '0;
    else if (enable) cnt <= cnt + 8'd1;
  end

  // cnt holds the ack-less BUSY cycles already elapsed, so the current
  // cycle is the LIMIT-th when cnt == LIMIT-1.
  assign expired = enable && (cnt == 8'(LIMIT - 1));

endmodule

// File: rtl/mem_access_unit.sv
// Multicycle-CPU memory access unit: turns controller strobes into a
// req/ack memory handshake and stalls the controller until it completes.
//   clk, rst                      : clock, async active-high reset
//   PC, ALUResult, WriteData      : fetch address, data address, store data
//   IRWrite, AdrSrc, MemWrite     : controller strobes (access decode)
//   Instr, OldPC, Data            : instruction reg, its PC, memory data reg
//   stall                         : freeze controller while an access is live
//   mem_req/mem_we/mem_addr/mem_wdata, mem_ack/mem_rdata : memory side
//   err                           : sticky timeout flag
// Build option: define MEM_TIMEOUT_EN to enable the BUSY watchdog
// (TIMEOUT_CYCLES); otherwise BUSY waits forever and err is tied 0.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PC,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  input  logic        IRWrite,
  input  logic        AdrSrc,
  input  logic        MemWrite,
  output logic [31:0] Instr,
  output logic [31:0] OldPC,
  output logic [31:0] Data,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        err
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("mem_access_unit: TIMEOUT_CYCLES out of range 2..255");
  end

  state_t state, state_nxt;
  acc_t   acc;
  mreq_t  lat;
  logic   start, ack_ok, expired;

  assign acc    = decode_acc(IRWrite, AdrSrc, MemWrite);
  assign start  = (state == ST_IDLE) && (acc != ACC_NONE);
  assign ack_ok = (state == ST_BUSY) && mem_ack;

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // next state; ack beats a simultaneous timeout
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_BUSY;
      ST_BUSY: begin
        if (mem_ack)      state_nxt = ST_DONE;
        else if (expired) state_nxt = ST_ERROR;
      end
      ST_DONE:  state_nxt = ST_IDLE;
      ST_ERROR: state_nxt = ST_ERROR;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // outputs are decoded from the state register so an async reset drops
  // mem_req without waiting for an edge
  always_comb begin
    stall   = 1'b0;
    mem_req = 1'b0;
    mem_we  = 1'b0;
    case (state)
      ST_IDLE:  stall = start;
      ST_BUSY: begin
        stall   = 1'b1;
        mem_req = 1'b1;
        mem_we  = lat.we;
      end
      ST_ERROR: stall = 1'b1;
      default: ;
    endcase
  end

  assign mem_addr  = lat.addr;
  assign mem_wdata = lat.wdata;

  // request latch: address/data frozen for the whole BUSY phase
  always_ff @(posedge clk or posedge rst) begin
    if (rst) lat <= '0;
    else if (start) begin
      lat.kind  <= acc;
      lat.we    <= (acc == ACC_STORE);
      lat.addr  <= (acc == ACC_FETCH) ? PC : ALUResult;
      lat.wdata <= WriteData;
    end
  end

  // result capture on the acked edge; stores touch nothing
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Instr <= '0;
      OldPC <= '0;
      Data  <= '0;
    end else if (ack_ok) begin
      case (lat.kind)
        ACC_FETCH: begin
          Instr <= mem_rdata;
          OldPC <= PC;
        end
        ACC_LOAD:  Data <= mem_rdata;
        default: ;
      endcase
    end
  end

`ifdef MEM_TIMEOUT_EN
  logic err_q;

  mem_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_wdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (start),
    .enable ((state == ST_BUSY) && !mem_ack),
    .expired(expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                   err_q <= 1'b0;
    else if ((state == ST_BUSY) && !mem_ack && expired) err_q <= 1'b1;
  end

  assign err = err_q;
`else
  assign expired = 1'b0;
  assign err     = 1'b0;
`endif

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, 16, max BUSY cycles before error (range 2..255).
REQ-002 SHALL have a single clock and asynchronous active-high reset: clk  in  1  rising-edge clock.
REQ-003 SHALL have port: rst  in  1  asynchronous active-high reset.
REQ-004 SHALL have port: PC  in  32  fetch address.
REQ-005 SHALL have port: ALUResult  in  32  data address.
REQ-006 SHALL have port: WriteData  in  32  store data.
REQ-007 SHALL have ports from controller: IRWrite, AdrSrc, MemWrite  in  1 each.
REQ-008 SHALL have port: Instr  out  32  instruction register.
REQ-009 SHALL have port: OldPC  out  32  PC of latched instruction.
REQ-010 SHALL have port: Data  out  32  memory data register.
REQ-011 SHALL have port: stall  out  1  freeze controller state and PCWrite/RegWrite.
REQ-012 SHALL have memory-side ports: mem_req, mem_we  out  1; mem_addr, mem_wdata  out  32.
REQ-013 SHALL have memory-side ports: mem_ack  in  1; mem_rdata  in  32.
REQ-014 SHALL have port: err  out  1  sticky timeout flag.

Function
REQ-015 SHALL decode access type: fetch = IRWrite; store = AdrSrc & MemWrite; load = AdrSrc & ~MemWrite & ~IRWrite; none otherwise.
REQ-016 SHALL implement FSM with states IDLE, BUSY, DONE, ERROR.
REQ-017 IDLE with access present SHALL do three things: latch address (PC for fetch, else ALUResult), we and wdata; go to BUSY; drive stall=1 combinationally in that cycle.
REQ-018 BUSY SHALL drive mem_req=1, latched mem_addr/mem_we/mem_wdata stable, and stall=1.
REQ-019 BUSY with mem_ack=1 SHALL, at that edge, load mem_rdata into Instr and PC into OldPC (fetch) or into Data (load), then go to DONE.
REQ-020 A store SHALL leave Instr, OldPC and Data unchanged.
REQ-021 DONE SHALL drive stall=0 and mem_req=0, ignore the still-asserted access, and go to IDLE next cycle.
REQ-022 Latency SHALL be as follows: access at cycle N with ack at cycle M≥N+1 gives stall high N..M, low at M+1. Zero-wait ack (M=N+1) gives 2 stall cycles.
REQ-023 mem_ack outside BUSY SHALL be ignored.
REQ-024 stall SHALL be 0 in IDLE without access.

Reset
REQ-025 rst SHALL asynchronously force the following: state=IDLE; Instr, OldPC, Data, latched address/wdata = 0; mem_req=mem_we=0; err=0; timeout counter=0.
REQ-026 rst asserted mid-BUSY SHALL drop mem_req immediately, without waiting for a clock edge. A late ack after release SHALL be ignored.

Configuration
REQ-027 With MEM_TIMEOUT_EN defined, a counter SHALL clear on BUSY entry and increment each BUSY cycle without ack.
REQ-028 With MEM_TIMEOUT_EN defined, reaching TIMEOUT_CYCLES SHALL cause the following: drop mem_req; set err; enter ERROR.
REQ-029 ERROR SHALL hold stall=1 and mem_req=0 until reset.
REQ-030 Without MEM_TIMEOUT_EN, BUSY SHALL wait indefinitely, err SHALL be tied 0, and ERROR SHALL be unreachable.

Structure
REQ-031 The shared package SHALL hold state encodings (2-bit), access-type encoding (NONE/FETCH/LOAD/STORE) and default TIMEOUT_CYCLES.
REQ-032 The timeout counter SHALL be sub-module mem_watchdog (inputs clk, rst, clear, enable; output expired), instantiated only under MEM_TIMEOUT_EN.

Verification
REQ-033 Fetch, zero-wait: PC=0x00000010, IRWrite=1, ack one cycle after req with rdata=0x00A00093 -> stall 2 cycles, then Instr=0x00A00093 and OldPC=0x10.
REQ-034 Load, 3-wait: AdrSrc=1, ALUResult=0x00000104, ack 3 cycles after req with rdata=0xDEADBEEF -> mem_addr=0x104 and mem_we=0 throughout, Data=0xDEADBEEF, Instr unchanged.
REQ-035 Store: AdrSrc=1, MemWrite=1, ALUResult=0x200, WriteData=0x12345678, ALUResult changed mid-BUSY -> mem_addr/mem_wdata hold 0x200/0x12345678, mem_we=1, Data unchanged.
REQ-036 Spurious ack in IDLE with rdata=0xFFFFFFFF -> no register change, stall=0.
REQ-037 Reset mid-BUSY: assert rst 2 cycles after req -> mem_req low before next edge; after release, ack pulse is ignored and state is IDLE.
REQ-038 MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> err=1 after 4 BUSY cycles, mem_req=0, stall stays 1 until rst.
